nkmm_dbus_mmio: RTL and testbench
=================================

NKMM_DBUS_MMIO -- requirements
Module: nkmm_dbus_mmio

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port addr_i  input  `ADDR_WIDTH  CPU data-bus address.
REQ-004 SHALL have port data_i  input  `ACCUM_WIDTH  CPU write data.
REQ-005 SHALL have port we_i  input  1  CPU write strobe, one cycle per write.
REQ-006 SHALL have port data_o  output  `ACCUM_WIDTH  read data to CPU, one cycle after addr_i.
REQ-007 SHALL have ports tx_data_o  output  `ACCUM_WIDTH, tx_valid_o  output  1, tx_ready_i  input  1  TX stream out.
REQ-008 SHALL have ports rx_data_i  input  `ACCUM_WIDTH, rx_valid_i  input  1, rx_ready_o  output  1  RX stream in.
REQ-009 SHALL have parameter RAM_AW, default 8, scratch RAM address width (2^RAM_AW words).
REQ-010 SHALL have parameter FIFO_AW, default 3, FIFO depth 2^FIFO_AW (8).

Function
REQ-011 Decode: addr_i[`ADDR_WIDTH-1]=0 selects scratch RAM word addr_i[RAM_AW-1:0]; =1 selects MMIO register addr_i[1:0].
REQ-012 MMIO map: 0 TX_DATA (W: push), 1 RX_DATA (R: head, no side effect), 2 STATUS (R; W: clear sticky flags), 3 RX_POP (W: pop, data ignored).
REQ-013 Reads are side-effect free; data_o is registered: value for addr_i at edge N appears after edge N, held until edge N+1.
REQ-014 RAM write when we_i and RAM selected; read in the same cycle as a write to the same word returns old contents; read one cycle later returns new.
REQ-015 STATUS bits: [0] tx_full, [1] tx_empty, [2] rx_nonempty, [3] tx_overflow (sticky), [4] rx_underflow (sticky), [8+:FIFO_AW+1] tx_count, [12+:FIFO_AW+1] rx_count; other bits 0.
REQ-016 TX push accepted when tx_count<depth, or when tx_count=depth and tx_valid_o&tx_ready_i same cycle; otherwise dropped and tx_overflow set.
REQ-017 tx_valid_o = tx_count!=0; tx_data_o = TX head (first-word-fall-through); pop on tx_valid_o&tx_ready_i.
REQ-018 rx_ready_o = rx_count<depth (no same-cycle pop bypass); RX push on rx_valid_i&rx_ready_o.
REQ-019 RX_POP write with rx_count=0 SHALL leave FIFO unchanged and set rx_underflow; RX_DATA read when empty returns 0.
REQ-020 Simultaneous push and pop on either FIFO: count unchanged, both take effect; pointers wrap modulo depth.
REQ-021 STATUS write clears sticky flags whose data_i bit is 1; a flag set and cleared in the same cycle ends set.

Reset
REQ-022 On rst_n=0 at an edge: FIFO pointers/counts 0, sticky flags 0, data_o 0, tx_valid_o 0, rx_ready_o 1 after release; RAM contents not reset.
REQ-023 Reset asserted mid-transfer SHALL discard FIFO contents; no TX handshake is reported in the reset cycle.

Configuration
REQ-024 Macro NKMM_DBUS_MMIO_RX_EN defined: RX FIFO, RX_DATA, RX_POP, rx status bits present as above.
REQ-025 Macro undefined: no RX storage; rx_ready_o tied 0; RX_DATA reads 0; RX_POP ignored; STATUS bits 2, 4, and rx_count read 0.

Structure
REQ-026 Address-map constants (MMIO_TX_DATA, MMIO_RX_DATA, MMIO_STATUS, MMIO_RX_POP) and STATUS bit positions SHALL live in nkmm_const.v.
REQ-027 One sub-module nkmm_sync_fifo (parameter WIDTH, AW; push/pop/full/empty/count, first-word-fall-through) SHALL be instantiated for TX and RX.

Verification
REQ-028 Write 0x1234 to RAM word 5, read word 5 next cycle -> data_o=0x1234 one cycle after read address.
REQ-029 tx_ready_i=0, push 9 words -> tx_count=8, STATUS[0]=1, STATUS[3]=1; words 1..8 emitted in order after tx_ready_i=1.
REQ-030 TX full, push with tx_ready_i=1 same cycle -> accepted, count stays 8, no overflow.
REQ-031 Feed rx 0xA,0xB; read RX_DATA -> 0xA twice; write RX_POP; read RX_DATA -> 0xB; pop twice -> STATUS[4]=1, write STATUS 0x10 -> cleared.
REQ-032 Fill RX to 8 -> rx_ready_o=0; rx_valid_i held, pop once -> rx_ready_o=1 next cycle, ninth word accepted.
REQ-033 Assert rst_n=0 with both FIFOs partially full -> counts 0, tx_valid_o=0, STATUS reads 0x0002; without NKMM_DBUS_MMIO_RX_EN rx_ready_o stays 0.

Source files
------------

// File: rtl/nkmm_dbus_mmio_pkg.sv
// Types and helpers shared by the data-bus MMIO block, built on the constants in nkmm_const.v.
`include "nkmm_const.v"
package nkmm_dbus_mmio_pkg;
  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int DATA_W = `ACCUM_WIDTH;

  typedef enum logic [1:0] {
    REG_TX_DATA = `MMIO_TX_DATA,
    REG_RX_DATA = `MMIO_RX_DATA,
    REG_STATUS  = `MMIO_STATUS,
    REG_RX_POP  = `MMIO_RX_POP
  } mmio_reg_e;

  // Top address bit splits the bus between scratch RAM and the register window.
  function automatic logic is_mmio(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1];
  endfunction
endpackage

// File: rtl/nkmm_const.v
// Shared bus widths, MMIO register map and STATUS bit positions for the nkmm data-bus block.
`ifndef NKMM_CONST_V
`define NKMM_CONST_V
`define ADDR_WIDTH       16
`define ACCUM_WIDTH      16
`define MMIO_TX_DATA     2'd0
`define MMIO_RX_DATA     2'd1
`define MMIO_STATUS      2'd2
`define MMIO_RX_POP      2'd3
`define STAT_TX_FULL     0
`define STAT_TX_EMPTY    1
`define STAT_RX_NONEMPTY 2
`define STAT_TX_OVF      3
`define STAT_RX_UNF      4
`define STAT_TX_COUNT    8
`define STAT_RX_COUNT    12
`endif

// File: rtl/nkmm_dbus_mmio_fifo.sv
// nkmm_sync_fifo: first-word-fall-through synchronous FIFO, depth 2^AW, push accepted when full if popping.
`include "nkmm_const.v"
module nkmm_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Count never exceeds the depth, so its top bit alone marks full.
  assign full_o    = r_count[AW];
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);
  assign data_o    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/nkmm_dbus_mmio.sv
// Data-bus MMIO: scratch RAM plus TX/RX stream FIFOs behind a four-register window.
// Define NKMM_DBUS_MMIO_RX_EN to build the RX path; without it RX is absent and reads as zero.
`include "nkmm_const.v"
module nkmm_dbus_mmio
  import nkmm_dbus_mmio_pkg::*;
#(
  parameter int RAM_AW  = 8,
  parameter int FIFO_AW = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [`ADDR_WIDTH-1:0]  addr_i,
  input  logic [`ACCUM_WIDTH-1:0] data_i,
  input  logic                    we_i,
  output logic [`ACCUM_WIDTH-1:0] data_o,
  output logic [`ACCUM_WIDTH-1:0] tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  input  logic [`ACCUM_WIDTH-1:0] rx_data_i,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o
);
  localparam int CW = FIFO_AW + 1;

  logic             w_mmio_sel;
  mmio_reg_e        w_reg;
  logic             w_wr_mmio;
  logic             w_stat_wr;
  logic             w_unused_addr;
  logic [RAM_AW-1:0] w_ram_addr;

  assign w_mmio_sel    = is_mmio(addr_i);
  assign w_reg         = mmio_reg_e'(addr_i[1:0]);
  assign w_wr_mmio     = we_i & w_mmio_sel;
  assign w_stat_wr     = w_wr_mmio & (w_reg == REG_STATUS);
  assign w_ram_addr    = addr_i[RAM_AW-1:0];
  assign w_unused_addr = ^addr_i;

  logic              w_tx_push_req;
  logic              w_tx_pop;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic              w_tx_ovf_set;
  logic [CW-1:0]     w_tx_count;
  logic [DATA_W-1:0] w_tx_head;

  // Gating with rst_n keeps a stale head from handshaking during the reset cycle.
  assign tx_valid_o    = ~w_tx_empty & rst_n;
  assign tx_data_o     = w_tx_head;
  assign w_tx_pop      = tx_valid_o & tx_ready_i;
  assign w_tx_push_req = w_wr_mmio & (w_reg == REG_TX_DATA);
  assign w_tx_ovf_set  = w_tx_push_req & w_tx_full & ~w_tx_pop;

  nkmm_sync_fifo #(.WIDTH(DATA_W), .AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_tx_push_req),
    .pop_i   (w_tx_pop),
    .data_i  (data_i),
    .data_o  (w_tx_head),
    .full_o  (w_tx_full),
    .empty_o (w_tx_empty),
    .count_o (w_tx_count)
  );

  logic              w_rx_nonempty;
  logic              w_rx_unf_set;
  logic [CW-1:0]     w_rx_count;
  logic [DATA_W-1:0] w_rx_head;

`ifdef NKMM_DBUS_MMIO_RX_EN
  logic              w_rx_full;
  logic              w_rx_empty;
  logic              w_rx_pop_req;
  logic              w_rx_push;
  logic [DATA_W-1:0] w_rx_dout;

  // No pop bypass: a full RX FIFO refuses data even in a cycle that pops.
  assign rx_ready_o    = ~w_rx_full;
  assign w_rx_push     = rx_valid_i & rx_ready_o;
  assign w_rx_pop_req  = w_wr_mmio & (w_reg == REG_RX_POP);
  assign w_rx_nonempty = ~w_rx_empty;
  assign w_rx_head     = w_rx_empty ? '0 : w_rx_dout;
  assign w_rx_unf_set  = w_rx_pop_req & w_rx_empty;

  nkmm_sync_fifo #(.WIDTH(DATA_W), .AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_rx_push),
    .pop_i   (w_rx_pop_req),
    .data_i  (rx_data_i),
    .data_o  (w_rx_dout),
    .full_o  (w_rx_full),
    .empty_o (w_rx_empty),
    .count_o (w_rx_count)
  );
`else
  logic w_unused_rx;
  assign w_unused_rx   = ^{rx_data_i, rx_valid_i};
  assign rx_ready_o    = 1'b0;
  assign w_rx_nonempty = 1'b0;
  assign w_rx_head     = '0;
  assign w_rx_unf_set  = 1'b0;
  assign w_rx_count    = '0;
`endif

  logic r_tx_ovf;
  logic r_rx_unf;

  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_ovf <= 1'b0;
      r_rx_unf <= 1'b0;
    end else begin
      r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~(w_stat_wr & data_i[`STAT_TX_OVF]));
      r_rx_unf <= w_rx_unf_set | (r_rx_unf & ~(w_stat_wr & data_i[`STAT_RX_UNF]));
    end
  end

  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_mmio_rd;

  always_comb begin
    w_status                          = '0;
    w_status[`STAT_TX_FULL]           = w_tx_full;
    w_status[`STAT_TX_EMPTY]          = w_tx_empty;
    w_status[`STAT_RX_NONEMPTY]       = w_rx_nonempty;
    w_status[`STAT_TX_OVF]            = r_tx_ovf;
    w_status[`STAT_RX_UNF]            = r_rx_unf;
    w_status[`STAT_TX_COUNT +: CW]    = w_tx_count;
    w_status[`STAT_RX_COUNT +: CW]    = w_rx_count;
  end

  always_comb begin
    w_mmio_rd = '0;
    case (w_reg)
      REG_RX_DATA: w_mmio_rd = w_rx_head;
      REG_STATUS:  w_mmio_rd = w_status;
      default:     w_mmio_rd = '0;
    endcase
  end

  logic [DATA_W-1:0] r_ram [0:(1<<RAM_AW)-1];
  logic [DATA_W-1:0] r_ram_q;
  logic [DATA_W-1:0] r_mmio_q;
  logic              r_sel_mmio;

  always_ff @(posedge clk) begin
    if (we_i && !w_mmio_sel) r_ram[w_ram_addr] <= data_i;
    r_ram_q <= r_ram[w_ram_addr];
  end

  // Resetting to the MMIO side with zero data gives data_o = 0 without resetting the RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel_mmio <= 1'b1;
      r_mmio_q   <= '0;
    end else begin
      r_sel_mmio <= w_mmio_sel;
      r_mmio_q   <= w_mmio_rd;
    end
  end

  assign data_o = r_sel_mmio ? r_mmio_q : r_ram_q;
endmodule

// File: tb/tb_nkmm_dbus_mmio.sv
// Directed self-checking bench for nkmm_dbus_mmio (RX checks follow NKMM_DBUS_MMIO_RX_EN).
module tb_nkmm_dbus_mmio;
  import nkmm_dbus_mmio_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] data_i;
  logic              we_i;
  logic [DATA_W-1:0] data_o;
  logic [DATA_W-1:0] tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i;
  logic [DATA_W-1:0] rx_data_i;
  logic              rx_valid_i;
  logic              rx_ready_o;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [15:0] A_TX  = 16'h8000;
  localparam logic [15:0] A_RX  = 16'h8001;
  localparam logic [15:0] A_ST  = 16'h8002;
  localparam logic [15:0] A_POP = 16'h8003;
`ifdef NKMM_DBUS_MMIO_RX_EN
  localparam logic RX_EN = 1'b1;
`else
  localparam logic RX_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  nkmm_dbus_mmio #(.RAM_AW(8), .FIFO_AW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .we_i       (we_i),
    .data_o     (data_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr_i = a; data_i = d; we_i = 1'b1;
    cyc();
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    addr_i = a; we_i = 1'b0;
    cyc();
    check(tag, {16'h0, data_o}, {16'h0, exp});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; addr_i = A_ST; data_i = '0; we_i = 1'b0;
    tx_ready_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0;
    cyc(); cyc();
    check("rst_data_o", {16'h0, data_o}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
    rst_n = 1'b1;
    cyc();
    check("post_rst_status", {16'h0, data_o}, 32'h0002);
    check("post_rst_rx_ready", {31'h0, rx_ready_o}, {31'h0, RX_EN});

    // Scratch RAM
    wr(16'h0005, 16'h1234);
    rd(16'h0005, 16'h1234, "ram_rd_w5");
    addr_i = 16'h0005; data_i = 16'h5678; we_i = 1'b1;
    cyc();
    we_i = 1'b0;
    check("ram_rd_old_same_cycle", {16'h0, data_o}, 32'h1234);
    rd(16'h0005, 16'h5678, "ram_rd_new");
    wr(16'h00FF, 16'hBEEF);
    rd(16'h00FF, 16'hBEEF, "ram_rd_top_word");
    rd(16'h0105, 16'h5678, "ram_alias_w5");

    // TX overflow with sink stalled
    for (int i = 0; i < 9; i++) wr(A_TX, 16'h0101 + 16'(i));
    rd(A_ST, 16'h0809, "tx_full_ovf_status");
    check("tx_valid_full", {31'h0, tx_valid_o}, 32'h1);
    check("tx_head_full", {16'h0, tx_data_o}, 32'h0101);
    wr(A_ST, 16'h0008);
    rd(A_ST, 16'h0801, "tx_ovf_cleared");
    tx_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tx_drain_%0d", i), {16'h0, tx_data_o}, 32'h0101 + 32'(i));
      cyc();
    end
    tx_ready_i = 1'b0;
    check("tx_valid_drained", {31'h0, tx_valid_o}, 32'h0);

    // Push into a full TX FIFO while it pops
    for (int i = 0; i < 8; i++) wr(A_TX, 16'h0201 + 16'(i));
    addr_i = A_TX; data_i = 16'h0209; we_i = 1'b1; tx_ready_i = 1'b1;
    cyc();
    we_i = 1'b0; tx_ready_i = 1'b0;
    check("tx_head_after_bypass", {16'h0, tx_data_o}, 32'h0202);
    rd(A_ST, 16'h0801, "tx_full_no_ovf");
    tx_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tx_drain2_%0d", i), {16'h0, tx_data_o}, (i == 7) ? 32'h0209 : 32'h0202 + 32'(i));
      cyc();
    end
    tx_ready_i = 1'b0;
    check("tx_valid_drained2", {31'h0, tx_valid_o}, 32'h0);

`ifdef NKMM_DBUS_MMIO_RX_EN
    rx_valid_i = 1'b1; rx_data_i = 16'h000A;
    cyc();
    rx_data_i = 16'h000B;
    cyc();
    rx_valid_i = 1'b0;
    rd(A_ST, 16'h2006, "rx_two_status");
    rd(A_RX, 16'h000A, "rx_head_a1");
    rd(A_RX, 16'h000A, "rx_head_a2");
    wr(A_POP, 16'hFFFF);
    rd(A_RX, 16'h000B, "rx_head_b");
    wr(A_POP, 16'h0000);
    wr(A_POP, 16'h0000);
    rd(A_ST, 16'h0012, "rx_underflow_status");
    rd(A_RX, 16'h0000, "rx_empty_read");
    wr(A_ST, 16'h0010);
    rd(A_ST, 16'h0002, "rx_unf_cleared");

    for (int i = 0; i < 8; i++) begin
      rx_data_i = 16'h0300 + 16'(i); rx_valid_i = 1'b1;
      cyc();
    end
    check("rx_ready_full", {31'h0, rx_ready_o}, 32'h0);
    rx_data_i = 16'h0308;
    wr(A_POP, 16'h0000);
    check("rx_ready_after_pop", {31'h0, rx_ready_o}, 32'h1);
    cyc();
    rx_valid_i = 1'b0;
    rd(A_ST, 16'h8006, "rx_refull_status");
    rd(A_RX, 16'h0301, "rx_head_after_refill");
`else
    rx_valid_i = 1'b1; rx_data_i = 16'h0055;
    cyc();
    check("rx_ready_tied", {31'h0, rx_ready_o}, 32'h0);
    wr(A_POP, 16'h0000);
    rd(A_ST, 16'h0002, "norx_status");
    rd(A_RX, 16'h0000, "norx_rx_data");
    rx_valid_i = 1'b0;
`endif

    // Reset with FIFOs holding data
    for (int i = 0; i < 3; i++) wr(A_TX, 16'h0401 + 16'(i));
    check("tx_valid_before_rst", {31'h0, tx_valid_o}, 32'h1);
    rst_n = 1'b0; tx_ready_i = 1'b1;
    #1;
    check("tx_valid_in_rst", {31'h0, tx_valid_o}, 32'h0);
    cyc();
    check("rst2_data_o", {16'h0, data_o}, 32'h0);
    rst_n = 1'b1; tx_ready_i = 1'b0; addr_i = A_ST;
    cyc();
    check("rst2_status", {16'h0, data_o}, 32'h0002);
    check("rst2_tx_valid", {31'h0, tx_valid_o}, 32'h0);
    check("rst2_rx_ready", {31'h0, rx_ready_o}, {31'h0, RX_EN});
    rd(A_RX, 16'h0000, "rst2_rx_data");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
